sprite_ram_loader: RTL and testbench

- Write-side counterpart of the sprite-sheet ROM/RAM readers.
- Accepts a start command with a sheet geometry, then a valid/ready byte stream of 8-bit palette indices.
- Writes the stream into a sprite RAM write port in the same linear layout the readers index: addr = base + frame*W*H + y*W + x.
- Sits between the host/upload path (NIOS/UART byte source) and the sprite RAMs, so new animation sheets can be loaded without re-synthesis.

---
 rtl/sprite_ram_loader_if.sv | 43 ++++
 rtl/sprite_ram_loader.sv | 195 +++++++++++++++++++
 tb/tb_sprite_ram_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_ram_loader_if.sv
// Command, pixel-stream and RAM write-port bundle for the sprite RAM loader.
// The host/upload side uses the master modport; the loader uses the slave modport.
interface sprite_ram_loader_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] cfg_base;
  logic [9:0]        cfg_width;
  logic [9:0]        cfg_height;
  logic [7:0]        cfg_frames;
  logic              key_en;
  logic [DATA_W-1:0] key_value;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_address;
  logic [DATA_W-1:0] wr_data;

  logic              busy;
  logic              done;
  logic              err;
  logic [7:0]        cur_frame;

  modport master (
    output start, cfg_base, cfg_width, cfg_height, cfg_frames, key_en, key_value,
    output in_data, in_valid,
    input  in_ready,
    input  wr_en, wr_address, wr_data,
    input  busy, done, err, cur_frame
  );

  modport slave (
    input  start, cfg_base, cfg_width, cfg_height, cfg_frames, key_en, key_value,
    input  in_data, in_valid,
    output in_ready,
    output wr_en, wr_address, wr_data,
    output busy, done, err, cur_frame
  );
endinterface

// File: rtl/sprite_ram_loader.sv
// Streams 8-bit palette indices into a sprite RAM write port using the same
// linear frame/row/column layout the sprite-sheet readers index.
module sprite_ram_loader #(
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 17640
) (
  input logic               Clk,
  input logic               Reset,
  sprite_ram_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DONE
  } state_t;

  localparam logic [28:0] LP_DEPTH = 29'(MEM_DEPTH);

  state_t r_state;
  state_t w_nextState;

  logic [ADDR_W-1:0] r_base;
  logic [9:0]        r_width;
  logic [9:0]        r_height;
  logic [27:0]       r_total;
  logic              r_keyEn;
  logic [DATA_W-1:0] r_keyValue;

  logic [9:0]        r_x;
  logic [9:0]        r_y;
  logic [7:0]        r_curFrame;
  logic [27:0]       r_offset;

  logic              r_wrEn;
  logic [ADDR_W-1:0] r_wrAddress;
  logic [DATA_W-1:0] r_wrData;
  logic              r_err;

  logic              w_inReady;
  logic              w_busy;
  logic              w_done;
  logic              w_accept;
  logic              w_lastBeat;
  logic              w_skip;
  logic              w_startIdle;
  logic              w_cfgOk;
  logic [27:0]       w_cfgProduct;
  logic [28:0]       w_cfgEnd;
  logic [ADDR_W-1:0] w_address;

  // Bound check is evaluated on the raw cfg inputs in the start cycle; the
  // 29-bit sum keeps a huge base from wrapping past the depth check.
  assign w_cfgProduct = 28'(bus.cfg_width) * 28'(bus.cfg_height) * 28'(bus.cfg_frames);
  assign w_cfgEnd     = 29'(bus.cfg_base) + 29'(w_cfgProduct);
  assign w_cfgOk      = (bus.cfg_width != 10'd0) && (bus.cfg_height != 10'd0) &&
                        (bus.cfg_frames != 8'd0) && (w_cfgEnd <= LP_DEPTH);

  assign w_startIdle = (r_state == S_IDLE) && bus.start;
  assign w_accept    = bus.in_valid && w_inReady;
  assign w_lastBeat  = (r_offset == (r_total - 28'd1));
  assign w_skip      = r_keyEn && (bus.in_data == r_keyValue);
  assign w_address   = r_base + r_offset[ADDR_W-1:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start && w_cfgOk) begin
          w_nextState = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && w_lastBeat) begin
          w_nextState = S_DONE;
        end
      end
      S_DONE: begin
        w_nextState = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_inReady = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_inReady = 1'b1;
        w_busy    = 1'b1;
      end
      S_DONE: begin
        w_busy = 1'b1;
        w_done = 1'b1;
      end
      default: begin
        w_inReady = 1'b0;
      end
    endcase
  end

  // Configuration is captured on every idle start, even a rejected one; the
  // counters are only cleared when the load really begins.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_base     <= '0;
      r_width    <= '0;
      r_height   <= '0;
      r_total    <= '0;
      r_keyEn    <= 1'b0;
      r_keyValue <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_startIdle) begin
        r_base     <= bus.cfg_base;
        r_width    <= bus.cfg_width;
        r_height   <= bus.cfg_height;
        r_total    <= w_cfgProduct;
        r_keyEn    <= bus.key_en;
        r_keyValue <= bus.key_value;
        r_err      <= !w_cfgOk;
      end
    end
  end

  // Position counters: x/y/frame track the sheet geometry for cur_frame while
  // the flat offset alone forms the address, so no multiplier is needed here.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_x        <= '0;
      r_y        <= '0;
      r_curFrame <= '0;
      r_offset   <= '0;
    end else if (w_startIdle && w_cfgOk) begin
      r_x        <= '0;
      r_y        <= '0;
      r_curFrame <= '0;
      r_offset   <= '0;
    end else if (w_accept) begin
      r_offset <= r_offset + 28'd1;
      if (r_x == (r_width - 10'd1)) begin
        r_x <= '0;
        if (r_y == (r_height - 10'd1)) begin
          r_y <= '0;
          if (!w_lastBeat) begin
            r_curFrame <= r_curFrame + 8'd1;
          end
        end else begin
          r_y <= r_y + 10'd1;
        end
      end else begin
        r_x <= r_x + 10'd1;
      end
    end
  end

  // Write port: one cycle behind acceptance; keyed pixels still consume an address.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wrEn      <= 1'b0;
      r_wrAddress <= '0;
      r_wrData    <= '0;
    end else begin
      r_wrEn <= w_accept && !w_skip;
      if (w_accept) begin
        r_wrAddress <= w_address;
        r_wrData    <= bus.in_data;
      end
    end
  end

  assign bus.in_ready   = w_inReady;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.err        = r_err;
  assign bus.wr_en      = r_wrEn;
  assign bus.wr_address = r_wrAddress;
  assign bus.wr_data    = r_wrData;
  assign bus.cur_frame  = r_curFrame;

endmodule

// File: tb/tb_sprite_ram_loader.sv
// Directed bench for sprite_ram_loader: drives inputs on the falling edge and
// checks registered outputs 1 ns after each rising edge.
module tb_sprite_ram_loader;

  logic Clk;
  logic Reset;

  int vectorCount;
  int missCount;

  logic [7:0] beatData [0:63];

  sprite_ram_loader_if #(.ADDR_W(19), .DATA_W(8)) bus ();

  sprite_ram_loader #(
    .ADDR_W   (19),
    .DATA_W   (8),
    .MEM_DEPTH(17640)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge Clk);
    #1;
  endtask

  // Presents one start strobe and returns 1 ns after the sampling edge.
  task automatic applyStimulus(input logic [18:0] base, input logic [9:0] w, input logic [9:0] h,
                               input logic [7:0] f, input logic keyEn, input logic [7:0] keyVal);
    @(negedge Clk);
    bus.start      = 1'b1;
    bus.cfg_base   = base;
    bus.cfg_width  = w;
    bus.cfg_height = h;
    bus.cfg_frames = f;
    bus.key_en     = keyEn;
    bus.key_value  = keyVal;
    bus.in_valid   = 1'b0;
    stepCycle();
    bus.start = 1'b0;
  endtask

  task automatic fillRamp(input int count, input logic [7:0] first);
    for (int i = 0; i < count; i++) beatData[i] = first + 8'(i);
  endtask

  // Runs a full load; gapMode 1 gives valid 1,0,1 repeating; a start with a
  // bad config is thrown in at cycle interruptCycle to prove it is ignored.
  task automatic runLoad(input logic [18:0] base, input logic [9:0] w, input logic [9:0] h,
                         input logic [7:0] f, input logic keyEn, input logic [7:0] keyVal,
                         input int gapMode, input int interruptCycle);
    int total;
    int beat;
    int cyc;
    int framePix;
    logic validNow;
    logic expWr;
    logic [7:0] expFrame;
    total    = int'(w) * int'(h) * int'(f);
    framePix = int'(w) * int'(h);
    beat     = 0;
    cyc      = 0;
    applyStimulus(base, w, h, f, keyEn, keyVal);
    checkOutput("start busy", 32'(bus.busy), 32'd1);
    checkOutput("start in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("start err", 32'(bus.err), 32'd0);
    while (beat < total && cyc < 4 * total + 20) begin
      @(negedge Clk);
      validNow     = (gapMode == 0) ? 1'b1 : ((cyc % 3) != 1);
      bus.in_valid = validNow;
      bus.in_data  = beatData[beat];
      bus.start    = (cyc == interruptCycle);
      if (cyc == interruptCycle) begin
        bus.cfg_base   = 19'd500;
        bus.cfg_width  = 10'd0;
        bus.cfg_height = 10'd7;
        bus.cfg_frames = 8'd3;
      end
      stepCycle();
      if (validNow) begin
        expWr = !(keyEn && (beatData[beat] == keyVal));
        checkOutput("wr_en", 32'(bus.wr_en), 32'(expWr));
        if (expWr) begin
          checkOutput("wr_address", 32'(bus.wr_address), 32'(base) + 32'(beat));
          checkOutput("wr_data", 32'(bus.wr_data), 32'(beatData[beat]));
        end
        checkOutput("done", 32'(bus.done), 32'(beat == total - 1));
        expFrame = (beat == total - 1) ? (f - 8'd1) : 8'((beat + 1) / framePix);
        checkOutput("cur_frame", 32'(bus.cur_frame), 32'(expFrame));
        beat++;
      end else begin
        checkOutput("wr_en on gap", 32'(bus.wr_en), 32'd0);
        checkOutput("done on gap", 32'(bus.done), 32'd0);
      end
      checkOutput("busy in load", 32'(bus.busy), 32'd1);
      checkOutput("in_ready", 32'(bus.in_ready), 32'(beat != total));
      checkOutput("err in load", 32'(bus.err), 32'd0);
      cyc++;
    end
    if (beat < total) checkOutput("load cycle budget", 32'(beat), 32'(total));
    @(negedge Clk);
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    stepCycle();
    checkOutput("after busy", 32'(bus.busy), 32'd0);
    checkOutput("after done", 32'(bus.done), 32'd0);
    checkOutput("after wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("after err", 32'(bus.err), 32'd0);
    checkOutput("after cur_frame", 32'(bus.cur_frame), 32'(f - 8'd1));
  endtask

  task automatic expectReject(input string tag, input logic [18:0] base, input logic [9:0] w,
                              input logic [9:0] h, input logic [7:0] f);
    applyStimulus(base, w, h, f, 1'b0, 8'h00);
    checkOutput({tag, " err"}, 32'(bus.err), 32'd1);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
    stepCycle();
    checkOutput({tag, " err clears"}, 32'(bus.err), 32'd0);
    checkOutput({tag, " stays idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vectorCount    = 0;
    missCount      = 0;
    Reset          = 1'b1;
    bus.start      = 1'b0;
    bus.cfg_base   = '0;
    bus.cfg_width  = '0;
    bus.cfg_height = '0;
    bus.cfg_frames = '0;
    bus.key_en     = 1'b0;
    bus.key_value  = '0;
    bus.in_data    = '0;
    bus.in_valid   = 1'b0;
    for (int i = 0; i < 64; i++) beatData[i] = '0;

    stepCycle();
    stepCycle();
    checkOutput("reset wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("reset wr_address", 32'(bus.wr_address), 32'd0);
    checkOutput("reset wr_data", 32'(bus.wr_data), 32'd0);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset err", 32'(bus.err), 32'd0);
    checkOutput("reset in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset cur_frame", 32'(bus.cur_frame), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    $display("[TB] basic load");
    fillRamp(8, 8'h10);
    runLoad(19'd0, 10'd2, 10'd2, 8'd2, 1'b0, 8'h00, 0, -1);

    $display("[TB] back-pressure gaps");
    fillRamp(8, 8'h20);
    runLoad(19'd0, 10'd2, 10'd2, 8'd2, 1'b0, 8'h00, 1, -1);

    $display("[TB] key skip");
    beatData[0] = 8'h01;
    beatData[1] = 8'hFF;
    beatData[2] = 8'h02;
    runLoad(19'd100, 10'd3, 10'd1, 8'd1, 1'b1, 8'hFF, 0, -1);

    $display("[TB] bad configs");
    expectReject("zero width", 19'd0, 10'd0, 10'd2, 8'd2);
    expectReject("zero height", 19'd0, 10'd2, 10'd0, 8'd2);
    expectReject("zero frames", 19'd0, 10'd2, 10'd2, 8'd0);
    expectReject("overrun", 19'd17600, 10'd50, 10'd1, 8'd1);
    fillRamp(50, 8'h40);
    runLoad(19'd17590, 10'd50, 10'd1, 8'd1, 1'b0, 8'h00, 0, -1);

    $display("[TB] reset mid-load");
    fillRamp(8, 8'h60);
    applyStimulus(19'd40, 10'd1, 10'd1, 8'd8, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      bus.in_valid = 1'b1;
      bus.in_data  = beatData[i];
      stepCycle();
      checkOutput("pre-reset wr_address", 32'(bus.wr_address), 32'd40 + 32'(i));
    end
    checkOutput("pre-reset cur_frame", 32'(bus.cur_frame), 32'd3);
    @(negedge Clk);
    Reset        = 1'b1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = beatData[3];
    stepCycle();
    checkOutput("abort wr_en", 32'(bus.wr_en), 32'd0);
    checkOutput("abort in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort cur_frame", 32'(bus.cur_frame), 32'd0);
    checkOutput("abort err", 32'(bus.err), 32'd0);
    @(negedge Clk);
    Reset        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    stepCycle();
    checkOutput("after reset idle", 32'(bus.busy), 32'd0);
    runLoad(19'd40, 10'd1, 10'd1, 8'd8, 1'b0, 8'h00, 0, -1);

    $display("[TB] start while busy");
    fillRamp(8, 8'h80);
    runLoad(19'd0, 10'd2, 10'd2, 8'd2, 1'b0, 8'h00, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
